// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe issue controller.
//   - ALU opcode encodings and the highest legal opcode
//   - register-index / opcode / address widths
//   - instruction word struct
//   - uses_rs1 / uses_rs2: which source registers an opcode reads
package pipe_pkg;

  localparam int REG_W  = 4;
  localparam int FUNC_W = 4;
  localparam int ADDR_W = 8;

  typedef enum logic [FUNC_W-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    AND = 4'd3,
    OR  = 4'd4,
    XOR = 4'd5,
    NOT = 4'd6,
    MOV = 4'd7,
    SLL = 4'd8,
    NEG = 4'd9,
    SRL = 4'd10,
    SLA = 4'd11
  } func_e;

  localparam logic [FUNC_W-1:0] FUNC_MAX = 4'd11;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  // Opcodes 0..5 read both sources; 6, 8, 10, 11 read rs1 only.
  function automatic logic uses_rs1(input logic [FUNC_W-1:0] f);
    return (f <= NOT) || (f == SLL) || (f == SRL) || (f == SLA);
  endfunction

  // Opcodes 0..5 read both sources; 7, 9 read rs2 only.
  function automatic logic uses_rs2(input logic [FUNC_W-1:0] f);
    return (f <= XOR) || (f == MOV) || (f == NEG);
  endfunction

endpackage

// File: rtl/pipe_issue_fifo.sv
// Synchronous FIFO with registered occupancy count and registered not-full.
//   clk, rst_n     : clock, async active-low reset
//   push, wdata    : write at tail (caller guarantees not_full)
//   pop            : drop head (caller guarantees count > 0)
//   rdata          : current head word
//   count          : registered entry count
//   count_nxt      : entry count after the coming edge
//   not_full       : registered, 0 while in reset
module pipe_issue_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 24,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          not_full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      not_full <= count_nxt < CW'(DEPTH);
    end
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller in front of the 4-stage ALU/memory pipe.
// Buffers instruction words, issues at most one per cycle, stalls the head on
// RAW hazards against destinations issued in the last HAZ_WIN cycles, drops
// illegal opcodes with a one-cycle flag, and counts issues/stalls.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid / in_ready        : upstream handshake (in_ready registered)
//   in_rs1/rs2/rd/func/addr    : incoming instruction word
//   iss_valid                  : one-cycle strobe, iss_* hold a new word
//   iss_rs1/rs2/rd/func/addr   : issued fields (held when no issue)
//   illegal                    : pulse after accepting func > FUNC_MAX
//   occupancy                  : FIFO entry count
//   idle                       : FIFO empty and hazard history clear
//   issue_cnt, stall_cnt       : saturating performance counters
module pipe_issue_ctrl
  import pipe_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int HAZ_WIN = 2,
  parameter  int CNT_W   = 16,
  localparam int OW      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              iss_valid,
  output logic [REG_W-1:0]  iss_rs1,
  output logic [REG_W-1:0]  iss_rs2,
  output logic [REG_W-1:0]  iss_rd,
  output logic [FUNC_W-1:0] iss_func,
  output logic [ADDR_W-1:0] iss_addr,
  output logic              illegal,
  output logic [OW-1:0]     occupancy,
  output logic              idle,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  instr_t                      in_w, head;
  logic [$bits(instr_t)-1:0]   head_bits;
  logic [OW-1:0]               occ_nxt;
  logic                        accept, legal, push;
  logic                        have_head, blocked, issue, stall;
  logic                        need1, need2;

  // Hazard history: slot 0 is the word issued at the previous edge.
  logic [HAZ_WIN-1:0]             vld_pipe, vld_nxt, hit;
  logic [HAZ_WIN-1:0][REG_W-1:0]  rd_pipe, rd_nxt;

  assign in_w = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};

  assign accept = in_valid && in_ready;
  assign legal  = in_func <= FUNC_MAX;
  assign push   = accept && legal;

  pipe_issue_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(instr_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     (in_w),
    .pop       (issue),
    .rdata     (head_bits),
    .count     (occupancy),
    .count_nxt (occ_nxt),
    .not_full  (in_ready)
  );

  assign head  = head_bits;
  assign need1 = uses_rs1(head.func);
  assign need2 = uses_rs2(head.func);

  // Per-slot RAW compare; only the sources the opcode actually reads count.
  for (genvar g = 0; g < HAZ_WIN; g++) begin : g_haz
    assign hit[g] = vld_pipe[g] &&
                    ((need1 && (rd_pipe[g] == head.rs1)) ||
                     (need2 && (rd_pipe[g] == head.rs2)));
  end

  assign blocked   = |hit;
  assign have_head = occupancy != '0;
  assign issue     = have_head && !blocked;
  assign stall     = have_head && blocked;

  always_comb begin
    vld_nxt[0] = issue;
    rd_nxt[0]  = head.rd;
    for (int i = 1; i < HAZ_WIN; i++) begin
      vld_nxt[i] = vld_pipe[i-1];
      rd_nxt[i]  = rd_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      rd_pipe   <= '0;
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
      illegal   <= 1'b0;
      issue_cnt <= '0;
      stall_cnt <= '0;
      idle      <= 1'b1;
    end else begin
      vld_pipe  <= vld_nxt;
      rd_pipe   <= rd_nxt;
      iss_valid <= issue;
      if (issue) begin
        iss_rs1  <= head.rs1;
        iss_rs2  <= head.rs2;
        iss_rd   <= head.rd;
        iss_func <= head.func;
        iss_addr <= head.addr;
      end
      illegal <= accept && !legal;
      if (issue && (issue_cnt != '1)) issue_cnt <= issue_cnt + CNT_W'(1);
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      // Registered from next-state so it lines up with occupancy/history.
      idle <= (occ_nxt == '0) && !(|vld_nxt);
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
module tb_pipe_issue_ctrl;
  import pipe_pkg::*;

  localparam int DEPTH   = 4;
  localparam int HAZ_WIN = 2;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 3;
  localparam int OW      = $clog2(DEPTH) + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
  logic [7:0] in_addr = '0;

  logic             in_ready, iss_valid, illegal, idle;
  logic [3:0]       iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]       iss_addr;
  logic [OW-1:0]    occupancy;
  logic [CNT_W-1:0] issue_cnt, stall_cnt;

  logic             s_in_ready, s_iss_valid, s_illegal, s_idle;
  logic [3:0]       s_iss_rs1, s_iss_rs2, s_iss_rd, s_iss_func;
  logic [7:0]       s_iss_addr;
  logic [OW-1:0]    s_occupancy;
  logic [SAT_W-1:0] s_issue_cnt, s_stall_cnt;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_func(iss_func), .iss_addr(iss_addr), .illegal(illegal), .occupancy(occupancy),
    .idle(idle), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt));

  // Narrow-counter copy so saturation is reachable in a short run.
  pipe_issue_ctrl #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
    .iss_valid(s_iss_valid), .iss_rs1(s_iss_rs1), .iss_rs2(s_iss_rs2), .iss_rd(s_iss_rd),
    .iss_func(s_iss_func), .iss_addr(s_iss_addr), .illegal(s_illegal), .occupancy(s_occupancy),
    .idle(s_idle), .issue_cnt(s_issue_cnt), .stall_cnt(s_stall_cnt));

  int n_chk  = 0;
  int n_fail = 0;
  bit saw_full = 0;

  // Reference model: a queue of words plus the edge number at which each
  // register was last written by an issued instruction.
  instr_t mq[$];
  int     last_rd[16];
  int     last_any;
  int     t_edge = 0;
  bit     m_ready, m_iv, m_ill, m_idle;
  instr_t m_iss;
  int     m_icnt, m_scnt;

  function automatic logic [1:0] srcs(input logic [3:0] f);  // {rs2, rs1}
    case (f)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 2'b11;
      4'd6, 4'd8, 4'd10, 4'd11:           return 2'b01;
      4'd7, 4'd9:                         return 2'b10;
      default:                            return 2'b00;
    endcase
  endfunction

  function automatic int cap(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 16; i++) last_rd[i] = t_edge - 1000;
    last_any = t_edge - 1000;
    m_ready = 0; m_iv = 0; m_ill = 0; m_idle = 1;
    m_iss = '0; m_icnt = 0; m_scnt = 0;
  endtask

  task automatic model_edge();
    bit acc, blk;
    logic [1:0] s;
    instr_t h;
    acc  = in_valid && m_ready;
    m_iv = 0;
    m_ill = 0;
    if (mq.size() > 0) begin
      h   = mq[0];
      s   = srcs(h.func);
      blk = (s[0] && (t_edge - last_rd[h.rs1] <= HAZ_WIN)) ||
            (s[1] && (t_edge - last_rd[h.rs2] <= HAZ_WIN));
      if (blk) m_scnt++;
      else begin
        m_iv = 1; m_iss = h; void'(mq.pop_front()); m_icnt++;
        last_rd[h.rd] = t_edge; last_any = t_edge;
      end
    end
    if (acc) begin
      if (in_func <= 4'd11) mq.push_back(instr_t'({in_rs1, in_rs2, in_rd, in_func, in_addr}));
      else m_ill = 1;
    end
    m_ready = mq.size() < DEPTH;
    m_idle  = (mq.size() == 0) && (t_edge - last_any >= HAZ_WIN);
    t_edge++;
  endtask

  task automatic check_all();
    chk("iss_valid", 32'(iss_valid), 32'(m_iv));
    chk("iss_word",  32'({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}), 32'(m_iss));
    chk("illegal",   32'(illegal), 32'(m_ill));
    chk("occupancy", 32'(occupancy), mq.size());
    chk("in_ready",  32'(in_ready), 32'(m_ready));
    chk("idle",      32'(idle), 32'(m_idle));
    chk("issue_cnt", 32'(issue_cnt), cap(m_icnt, CNT_W));
    chk("stall_cnt", 32'(stall_cnt), cap(m_scnt, CNT_W));
    chk("sat_issue_cnt", 32'(s_issue_cnt), cap(m_icnt, SAT_W));
    chk("sat_stall_cnt", 32'(s_stall_cnt), cap(m_scnt, SAT_W));
  endtask

  task automatic step(input bit v, input logic [3:0] r1, r2, rd, f, input logic [7:0] a);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_func = f; in_addr = a;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (occupancy == OW'(DEPTH)) begin
      saw_full = 1;
      chk("full_in_ready", 32'(in_ready), 0);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
  endtask

  task automatic do_reset(input int cycles);
    in_valid = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    repeat (cycles) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
  endtask

  task automatic push_word(input logic [3:0] r1, r2, rd, f);
    bit done;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      done = m_ready;
      step(1, r1, r2, rd, f, 8'(k + 16 * int'(rd)));
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: word rd=%0d not accepted within 20 cycles", rd);
    end
  endtask

  typedef struct {
    bit v; logic [3:0] rs1, rs2, rd, func;
    bit e_iv; logic [3:0] e_rd; int e_occ; int e_icnt; int e_scnt;
  } vec_t;

  vec_t tbl[9];
  int   base_ic, base_sc;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Independent pair, then add -> dependent sub (two stall cycles).
    tbl[0] = '{0, 0, 0, 0, 0,  0, 0,  0, 0, 0};
    tbl[1] = '{1, 3, 5, 10, 0, 0, 0,  1, 0, 0};
    tbl[2] = '{1, 3, 0, 12, 2, 1, 10, 1, 1, 0};
    tbl[3] = '{0, 0, 0, 0, 0,  1, 12, 0, 2, 0};
    tbl[4] = '{1, 3, 5, 10, 0, 0, 12, 1, 2, 0};
    tbl[5] = '{1, 10, 5, 14, 1, 1, 10, 1, 3, 0};
    tbl[6] = '{0, 0, 0, 0, 0,  0, 10, 1, 3, 1};
    tbl[7] = '{0, 0, 0, 0, 0,  0, 10, 1, 3, 2};
    tbl[8] = '{0, 0, 0, 0, 0,  1, 14, 0, 4, 2};

    #2;
    do_reset(3);
    chk("reset_idle", 32'(idle), 1);
    chk("reset_ready", 32'(in_ready), 0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].func, 8'(i));
      if (i == 0) chk("ready_after_release", 32'(in_ready), 1);
      chk("tbl_iss_valid", 32'(iss_valid), 32'(tbl[i].e_iv));
      chk("tbl_iss_rd", 32'(iss_rd), 32'(tbl[i].e_rd));
      chk("tbl_occupancy", 32'(occupancy), tbl[i].e_occ);
      chk("tbl_issue_cnt", 32'(issue_cnt), tbl[i].e_icnt);
      chk("tbl_stall_cnt", 32'(stall_cnt), tbl[i].e_scnt);
    end

    // Source masking: func 7 ignores rs1, func 9 reads rs2.
    idle_steps(3);
    base_sc = int'(stall_cnt);
    step(1, 4'd1, 4'd2, 4'd10, 4'd0, 8'h11);
    step(1, 4'd10, 4'd1, 4'd3, 4'd7, 8'h22);
    step(0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    chk("mask7_issue", 32'(iss_valid), 1);
    chk("mask7_func", 32'(iss_func), 7);
    chk("mask7_no_stall", 32'(stall_cnt), base_sc);
    step(1, 4'd1, 4'd2, 4'd10, 4'd0, 8'h33);
    step(1, 4'd1, 4'd10, 4'd4, 4'd9, 8'h44);
    step(0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    chk("mask9_stalled", 32'(iss_valid), 0);
    chk("mask9_stall_cnt", 32'(stall_cnt), base_sc + 1);
    idle_steps(6);

    // Fill the FIFO behind a dependency chain.
    base_ic = int'(issue_cnt);
    saw_full = 0;
    push_word(4'd0, 4'd0, 4'd9, 4'd0);
    push_word(4'd9, 4'd0, 4'd1, 4'd6);
    push_word(4'd1, 4'd0, 4'd2, 4'd6);
    push_word(4'd2, 4'd0, 4'd3, 4'd6);
    push_word(4'd3, 4'd0, 4'd4, 4'd6);
    push_word(4'd4, 4'd0, 4'd5, 4'd6);
    for (int k = 0; k < 60 && !(mq.size() == 0 && m_idle); k++) idle_steps(1);
    chk("full_seen", 32'(saw_full), 1);
    chk("drain_idle", 32'(idle), 1);
    chk("no_word_lost", int'(issue_cnt) - base_ic, 6);

    // Illegal opcode: dropped, flagged once, nothing issued.
    base_ic = int'(issue_cnt);
    step(1, 4'd1, 4'd2, 4'd3, 4'd12, 8'h55);
    chk("illegal_pulse", 32'(illegal), 1);
    chk("illegal_not_stored", 32'(occupancy), 0);
    step(0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    chk("illegal_clears", 32'(illegal), 0);
    chk("illegal_no_issue", 32'(iss_valid), 0);
    chk("illegal_issue_cnt", 32'(issue_cnt), base_ic);

    // Reset with three words in flight.
    idle_steps(3);
    push_word(4'd0, 4'd0, 4'd9, 4'd0);
    push_word(4'd9, 4'd0, 4'd1, 4'd6);
    push_word(4'd1, 4'd0, 4'd2, 4'd6);
    push_word(4'd2, 4'd0, 4'd3, 4'd6);
    chk("pre_reset_occ", 32'(occupancy), 3);
    do_reset(2);
    chk("midreset_occ", 32'(occupancy), 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
      chk("no_stale_issue", 32'(iss_valid), 0);
    end
    chk("post_reset_issue_cnt", 32'(issue_cnt), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 13)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
